// File: rtl/ysyx_22040750_pcgen_ctrl.sv
// Fetch PC owner: arbitrates trap/branch/sequential next PC, IF valid/ready handshake, redirect buffer, halt.
// Optional feature macro YSYX_22040750_PCGEN_ALIGN_CHK_EN: clear target bit0 and flag targets with bit1 set.
module ysyx_22040750_pcgen_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int              INST_B   = 4
) (
  input  logic            I_clk,
  input  logic            I_rst,
  output logic            O_fetch_valid,
  output logic [PC_W-1:0] O_fetch_pc,
  input  logic            I_fetch_ready,
  input  logic            I_br_valid,
  input  logic [PC_W-1:0] I_br_target,
  input  logic            I_trap_valid,
  input  logic [PC_W-1:0] I_trap_target,
  input  logic            I_halt,
  output logic            O_flush,
  output logic            O_halted,
  output logic            O_misalign,
  output logic [31:0]     O_redir_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pend_pc_r;
  logic            pend_v_r;
  logic            pend_trap_r;
  logic            halt_req_r;
  logic            valid_r;
  logic            halted_r;
  logic [31:0]     cnt_r;

  logic            fire_s;
  logic            br_take_s;
  logic            accept_s;
  logic            flush_s;
  logic            halt_go_s;
  logic            misalign_s;
  logic [PC_W-1:0] next_pc_s;

  function automatic logic [PC_W-1:0] align_tgt(input logic [PC_W-1:0] tgt);
`ifdef YSYX_22040750_PCGEN_ALIGN_CHK_EN
    align_tgt = tgt & {{(PC_W-1){1'b1}}, 1'b0};
`else
    align_tgt = tgt;
`endif
  endfunction

  // Per-state redirect acceptance, flush and halt decisions
  always_comb begin
    fire_s    = 1'b0;
    br_take_s = 1'b0;
    accept_s  = 1'b0;
    flush_s   = 1'b0;
    halt_go_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        fire_s    = valid_r & I_fetch_ready;
        // a branch loses to a same-cycle trap and never displaces a buffered trap
        br_take_s = I_br_valid & ~I_trap_valid & ~(pend_v_r & pend_trap_r);
        accept_s  = I_trap_valid | br_take_s;
        flush_s   = I_br_valid | I_trap_valid;
        halt_go_s = (halt_req_r | I_halt) & (fire_s | ~valid_r);
      end
      ST_HALT: begin
        accept_s = I_trap_valid;
        flush_s  = I_br_valid | I_trap_valid;
      end
      default: begin
        fire_s = 1'b0;
      end
    endcase
  end

  // Next PC on fire: live trap, buffered trap, live branch, buffered branch, sequential
  always_comb begin
    next_pc_s = pc_r + PC_W'(INST_B);
    if (I_trap_valid) begin
      next_pc_s = align_tgt(I_trap_target);
    end else if (pend_v_r && pend_trap_r) begin
      next_pc_s = pend_pc_r;
    end else if (I_br_valid) begin
      next_pc_s = align_tgt(I_br_target);
    end else if (pend_v_r) begin
      next_pc_s = pend_pc_r;
    end else begin
      next_pc_s = pc_r + PC_W'(INST_B);
    end
  end

`ifdef YSYX_22040750_PCGEN_ALIGN_CHK_EN
  logic [PC_W-1:0] sel_tgt_s;

  // Flag the accepted target (trap wins over branch) when its bit1 is set
  always_comb begin
    sel_tgt_s  = I_trap_valid ? I_trap_target : I_br_target;
    misalign_s = accept_s & sel_tgt_s[1];
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign O_flush       = flush_s & ~I_rst;
  assign O_misalign    = misalign_s & ~I_rst;
  assign O_fetch_valid = valid_r;
  assign O_fetch_pc    = pc_r;
  assign O_halted      = halted_r;
  assign O_redir_cnt   = cnt_r;

  // Control FSM with PC, redirect buffer, halt request and redirect counter
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      pend_pc_r   <= '0;
      pend_v_r    <= 1'b0;
      pend_trap_r <= 1'b0;
      halt_req_r  <= 1'b0;
      valid_r     <= 1'b0;
      halted_r    <= 1'b0;
      cnt_r       <= 32'd0;
    end else begin
      if (accept_s) begin
        cnt_r <= cnt_r + 32'd1;
      end
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_RUN;
          valid_r <= 1'b1;
        end
        ST_RUN: begin
          if (fire_s) begin
            pc_r        <= next_pc_s;
            pend_v_r    <= 1'b0;
            pend_trap_r <= 1'b0;
          end else if (I_trap_valid) begin
            pend_pc_r   <= align_tgt(I_trap_target);
            pend_v_r    <= 1'b1;
            pend_trap_r <= 1'b1;
          end else if (br_take_s) begin
            pend_pc_r   <= align_tgt(I_br_target);
            pend_v_r    <= 1'b1;
            pend_trap_r <= 1'b0;
          end
          if (halt_go_s) begin
            state_r    <= ST_HALT;
            valid_r    <= 1'b0;
            halted_r   <= 1'b1;
            halt_req_r <= 1'b0;
          end else if (I_halt) begin
            halt_req_r <= 1'b1;
          end
        end
        ST_HALT: begin
          // only a trap/interrupt resumes fetch
          if (I_trap_valid) begin
            state_r  <= ST_RUN;
            pc_r     <= align_tgt(I_trap_target);
            valid_r  <= 1'b1;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_BOOT;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_pcgen_ctrl.sv
// Directed self-checking bench for ysyx_22040750_pcgen_ctrl (default and ALIGN_CHK_EN builds).
module tb_ysyx_22040750_pcgen_ctrl;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        fetch_valid_s;
  logic [31:0] fetch_pc_s;
  logic        fetch_ready_s;
  logic        br_valid_s;
  logic [31:0] br_target_s;
  logic        trap_valid_s;
  logic [31:0] trap_target_s;
  logic        halt_s;
  logic        flush_s;
  logic        halted_s;
  logic        misalign_s;
  logic [31:0] redir_cnt_s;

  int vec_cnt = 0;
  int err_cnt = 0;

  ysyx_22040750_pcgen_ctrl dut (
    .I_clk         (clk_s),
    .I_rst         (rst_s),
    .O_fetch_valid (fetch_valid_s),
    .O_fetch_pc    (fetch_pc_s),
    .I_fetch_ready (fetch_ready_s),
    .I_br_valid    (br_valid_s),
    .I_br_target   (br_target_s),
    .I_trap_valid  (trap_valid_s),
    .I_trap_target (trap_target_s),
    .I_halt        (halt_s),
    .O_flush       (flush_s),
    .O_halted      (halted_s),
    .O_misalign    (misalign_s),
    .O_redir_cnt   (redir_cnt_s)
  );

  always #5 clk_s = ~clk_s;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  task automatic boot();
    rst_s = 1'b1; fetch_ready_s = 1'b1; halt_s = 1'b0;
    br_valid_s = 1'b0; br_target_s = 32'd0; trap_valid_s = 1'b0; trap_target_s = 32'd0;
    step();
    rst_s = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_s = 1'b1; fetch_ready_s = 1'b1; halt_s = 1'b0;
    br_valid_s = 1'b1; br_target_s = 32'h8000_0100; trap_valid_s = 1'b1; trap_target_s = 32'h8000_0400;
    step(); step();
    vec_cnt++; if (fetch_valid_s !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", fetch_valid_s); end
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0000) begin err_cnt++; $display("FAIL rst_pc: got %h want 80000000", fetch_pc_s); end
    vec_cnt++; if (flush_s !== 1'b0) begin err_cnt++; $display("FAIL rst_flush: got %b want 0", flush_s); end
    vec_cnt++; if (halted_s !== 1'b0 || misalign_s !== 1'b0) begin err_cnt++; $display("FAIL rst_halt_mis: got %b%b want 00", halted_s, misalign_s); end
    vec_cnt++; if (redir_cnt_s !== 32'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d want 0", redir_cnt_s); end
    rst_s = 1'b0;
    #1;
    // BOOT cycle: redirect inputs ignored, no valid yet
    vec_cnt++; if (fetch_valid_s !== 1'b0 || flush_s !== 1'b0) begin err_cnt++; $display("FAIL boot_cycle: got v%b f%b want v0 f0", fetch_valid_s, flush_s); end
    step();
    br_valid_s = 1'b0; trap_valid_s = 1'b0;
    vec_cnt++; if (fetch_valid_s !== 1'b1 || fetch_pc_s !== 32'h8000_0000) begin err_cnt++; $display("FAIL first_pc: got v%b %h want v1 80000000", fetch_valid_s, fetch_pc_s); end
    vec_cnt++; if (redir_cnt_s !== 32'd0) begin err_cnt++; $display("FAIL boot_cnt: got %0d want 0", redir_cnt_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0004) begin err_cnt++; $display("FAIL seq_pc1: got %h want 80000004", fetch_pc_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0008) begin err_cnt++; $display("FAIL seq_pc2: got %h want 80000008", fetch_pc_s); end
  endtask

  task automatic test_stall_branch();
    boot();
    for (int i = 0; i < 4; i++) step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0010) begin err_cnt++; $display("FAIL stall_pre_pc: got %h want 80000010", fetch_pc_s); end
    fetch_ready_s = 1'b0; br_valid_s = 1'b1; br_target_s = 32'h8000_0100;
    #1;
    vec_cnt++; if (flush_s !== 1'b1) begin err_cnt++; $display("FAIL stall_flush: got %b want 1", flush_s); end
    step();
    br_valid_s = 1'b0;
    #1;
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0010 || fetch_valid_s !== 1'b1) begin err_cnt++; $display("FAIL stall_hold: got v%b %h want v1 80000010", fetch_valid_s, fetch_pc_s); end
    vec_cnt++; if (flush_s !== 1'b0) begin err_cnt++; $display("FAIL stall_flush_once: got %b want 0", flush_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0010) begin err_cnt++; $display("FAIL stall_hold2: got %h want 80000010", fetch_pc_s); end
    fetch_ready_s = 1'b1;
    #1;
    vec_cnt++; if (flush_s !== 1'b0) begin err_cnt++; $display("FAIL drain_noflush: got %b want 0", flush_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0100) begin err_cnt++; $display("FAIL drain_pc: got %h want 80000100", fetch_pc_s); end
    vec_cnt++; if (redir_cnt_s !== 32'd1) begin err_cnt++; $display("FAIL drain_cnt: got %0d want 1", redir_cnt_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0104) begin err_cnt++; $display("FAIL pend_cleared: got %h want 80000104", fetch_pc_s); end
  endtask

  task automatic test_trap_priority();
    boot();
    fetch_ready_s = 1'b0; br_valid_s = 1'b1; br_target_s = 32'h8000_0100;
    step();
    br_valid_s = 1'b0; trap_valid_s = 1'b1; trap_target_s = 32'h8000_0400;
    step();
    trap_valid_s = 1'b0; br_valid_s = 1'b1; br_target_s = 32'h8000_0300;
    step();
    br_valid_s = 1'b0;
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0000 || redir_cnt_s !== 32'd2) begin err_cnt++; $display("FAIL trap_pend: got %h cnt %0d want 80000000 cnt 2", fetch_pc_s, redir_cnt_s); end
    fetch_ready_s = 1'b1;
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0400) begin err_cnt++; $display("FAIL trap_over_br: got %h want 80000400", fetch_pc_s); end
    vec_cnt++; if (redir_cnt_s !== 32'd2) begin err_cnt++; $display("FAIL trap_cnt: got %0d want 2", redir_cnt_s); end
    br_valid_s = 1'b1; br_target_s = 32'h8000_0500; trap_valid_s = 1'b1; trap_target_s = 32'h8000_0600;
    step();
    br_valid_s = 1'b0; trap_valid_s = 1'b0;
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0600 || redir_cnt_s !== 32'd3) begin err_cnt++; $display("FAIL simul_fire: got %h cnt %0d want 80000600 cnt 3", fetch_pc_s, redir_cnt_s); end
    fetch_ready_s = 1'b0;
    br_valid_s = 1'b1; br_target_s = 32'h8000_0700; trap_valid_s = 1'b1; trap_target_s = 32'h8000_0800;
    step();
    br_valid_s = 1'b0; trap_valid_s = 1'b0; fetch_ready_s = 1'b1;
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0800 || redir_cnt_s !== 32'd4) begin err_cnt++; $display("FAIL simul_stall: got %h cnt %0d want 80000800 cnt 4", fetch_pc_s, redir_cnt_s); end
  endtask

  task automatic test_halt();
    boot();
    for (int i = 0; i < 8; i++) step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0020) begin err_cnt++; $display("FAIL halt_pre_pc: got %h want 80000020", fetch_pc_s); end
    halt_s = 1'b1;
    step();
    halt_s = 1'b0;
    vec_cnt++; if (halted_s !== 1'b1 || fetch_valid_s !== 1'b0) begin err_cnt++; $display("FAIL halt_enter: got h%b v%b want h1 v0", halted_s, fetch_valid_s); end
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0024) begin err_cnt++; $display("FAIL halt_pc: got %h want 80000024", fetch_pc_s); end
    br_valid_s = 1'b1; br_target_s = 32'h8000_0900;
    #1;
    vec_cnt++; if (flush_s !== 1'b1) begin err_cnt++; $display("FAIL halt_br_flush: got %b want 1", flush_s); end
    step();
    br_valid_s = 1'b0;
    vec_cnt++; if (halted_s !== 1'b1 || fetch_valid_s !== 1'b0 || fetch_pc_s !== 32'h8000_0024 || redir_cnt_s !== 32'd0) begin
      err_cnt++; $display("FAIL halt_br_ignored: got h%b v%b %h cnt %0d want h1 v0 80000024 cnt 0", halted_s, fetch_valid_s, fetch_pc_s, redir_cnt_s);
    end
    trap_valid_s = 1'b1; trap_target_s = 32'h8000_0800;
    step();
    trap_valid_s = 1'b0;
    vec_cnt++; if (halted_s !== 1'b0 || fetch_valid_s !== 1'b1 || fetch_pc_s !== 32'h8000_0800 || redir_cnt_s !== 32'd1) begin
      err_cnt++; $display("FAIL halt_resume: got h%b v%b %h cnt %0d want h0 v1 80000800 cnt 1", halted_s, fetch_valid_s, fetch_pc_s, redir_cnt_s);
    end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0804) begin err_cnt++; $display("FAIL resume_seq: got %h want 80000804", fetch_pc_s); end
    // halt together with a stalled redirect: redirect lands first, then halt
    fetch_ready_s = 1'b0; halt_s = 1'b1; br_valid_s = 1'b1; br_target_s = 32'h8000_0a00;
    step();
    halt_s = 1'b0; br_valid_s = 1'b0;
    vec_cnt++; if (halted_s !== 1'b0 || fetch_pc_s !== 32'h8000_0804) begin err_cnt++; $display("FAIL halt_wait: got h%b %h want h0 80000804", halted_s, fetch_pc_s); end
    fetch_ready_s = 1'b1;
    step();
    vec_cnt++; if (halted_s !== 1'b1 || fetch_valid_s !== 1'b0 || fetch_pc_s !== 32'h8000_0a00) begin
      err_cnt++; $display("FAIL halt_after_redir: got h%b v%b %h want h1 v0 80000a00", halted_s, fetch_valid_s, fetch_pc_s);
    end
  endtask

  task automatic test_wrap_and_reset();
    boot();
    br_valid_s = 1'b1; br_target_s = 32'hffff_fffc;
    step();
    br_valid_s = 1'b0;
    vec_cnt++; if (fetch_pc_s !== 32'hffff_fffc) begin err_cnt++; $display("FAIL wrap_pre: got %h want fffffffc", fetch_pc_s); end
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h0000_0000) begin err_cnt++; $display("FAIL wrap_pc: got %h want 00000000", fetch_pc_s); end
    fetch_ready_s = 1'b0; br_valid_s = 1'b1; br_target_s = 32'h8000_0c00;
    step();
    br_valid_s = 1'b0; rst_s = 1'b1;
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0000 || fetch_valid_s !== 1'b0 || redir_cnt_s !== 32'd0) begin
      err_cnt++; $display("FAIL midrst: got v%b %h cnt %0d want v0 80000000 cnt 0", fetch_valid_s, fetch_pc_s, redir_cnt_s);
    end
    rst_s = 1'b0;
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0000 || fetch_valid_s !== 1'b1) begin err_cnt++; $display("FAIL midrst_boot: got v%b %h want v1 80000000", fetch_valid_s, fetch_pc_s); end
    fetch_ready_s = 1'b1;
    step();
    vec_cnt++; if (fetch_pc_s !== 32'h8000_0004) begin err_cnt++; $display("FAIL midrst_pend: got %h want 80000004", fetch_pc_s); end
  endtask

  task automatic test_align();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef YSYX_22040750_PCGEN_ALIGN_CHK_EN
    exp_pc = 32'h8000_0202; exp_mis = 1'b1;
`else
    exp_pc = 32'h8000_0203; exp_mis = 1'b0;
`endif
    boot();
    br_valid_s = 1'b1; br_target_s = 32'h8000_0203;
    #1;
    vec_cnt++; if (misalign_s !== exp_mis || flush_s !== 1'b1) begin err_cnt++; $display("FAIL align_flag: got m%b f%b want m%b f1", misalign_s, flush_s, exp_mis); end
    step();
    br_valid_s = 1'b0;
    #1;
    vec_cnt++; if (fetch_pc_s !== exp_pc) begin err_cnt++; $display("FAIL align_pc: got %h want %h", fetch_pc_s, exp_pc); end
    vec_cnt++; if (misalign_s !== 1'b0) begin err_cnt++; $display("FAIL align_pulse: got %b want 0", misalign_s); end
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_trap_priority();
    test_halt();
    test_wrap_and_reset();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
